// File: rtl/dram_sched_pkg.sv
// Shared definitions for the FSB DRAM/ROM scheduler: FSM encoding, timing defaults
// and a small saturating-increment helper.
package dram_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC_ROW,
        ACC_COL,
        REF_CAS,
        REF_RAS,
        REF_HOLD,
        PRECH
    } dramState_e;

    localparam int TRP_DEFAULT   = 2;
    localparam int ROMWS_DEFAULT = 3;

    function automatic logic [2:0] satInc3(input logic [2:0] value);
        return (value == 3'd7) ? value : value + 3'd1;
    endfunction

endpackage

// File: rtl/dram_sched_rom_ws.sv
// ROM wait-state counter: counts FSB cycles of a ROM bus cycle and raises ROMReady
// once ROMWS cycles have elapsed (immediately when ROMWS is zero).
module rom_ws
    import dram_sched_pkg::*;
#(
    parameter int ROMWS = ROMWS_DEFAULT
) (
    input  logic CLK,
    input  logic nRES,
    input  logic BACT,
    input  logic ROMCS,
    output logic ROMReady
);

    logic [2:0] waitCnt;
    logic       romCycle;

    assign romCycle = BACT & ROMCS;

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            waitCnt <= 3'd0;
        end else if (romCycle) begin
            waitCnt <= satInc3(waitCnt);
        end else begin
            waitCnt <= 3'd0;
        end
    end

    // Combinational so that a zero wait-state ROM answers in the first bus cycle.
    assign ROMReady = nRES & romCycle & (waitCnt >= 3'(ROMWS));

endmodule

// File: rtl/dram_sched.sv
// DRAM access/refresh scheduler for the FSB: RAS/CAS sequencing, CAS-before-RAS
// refresh with precharge, plus the independent ROM output-enable and wait states.
module dram_sched
    import dram_sched_pkg::*;
#(
    parameter int TRP   = TRP_DEFAULT,
    parameter int ROMWS = ROMWS_DEFAULT
) (
    input  logic CLK,
    input  logic nRES,
    input  logic BACT,
    input  logic RAMCS,
    input  logic ROMCS,
    input  logic nWE,
    input  logic nUDS,
    input  logic nLDS,
    input  logic RefReq,
    input  logic RefUrg,
    output logic RefAck,
    output logic nRAS,
    output logic nCAS,
    output logic RASEL,
    output logic nOE,
    output logic nLWE,
    output logic nUWE,
    output logic RAMReady,
    output logic ROMReady,
    output logic nROMOE
);

    localparam logic [1:0] TRP_CNT = 2'(TRP);

    dramState_e state;
    logic [1:0] prechCnt;
    logic       ramReq;
    logic       refStart;
    logic       colOE;
    logic       colLWE;
    logic       colUWE;

    assign ramReq   = BACT & RAMCS;
    assign refStart = RefUrg | (RefReq & ~ramReq);

    assign colOE  = ~nWE;
    assign colLWE = nWE | nLDS;
    assign colUWE = nWE | nUDS;

    // Strobes are computed alongside the next state so they register with it.
    // prechCnt is preloaded at reset so IDLE also waits out a full precharge.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state    <= IDLE;
            prechCnt <= TRP_CNT;
            nRAS     <= 1'b1;
            nCAS     <= 1'b1;
            RASEL    <= 1'b0;
            nOE      <= 1'b1;
            nLWE     <= 1'b1;
            nUWE     <= 1'b1;
            RefAck   <= 1'b0;
            RAMReady <= 1'b0;
        end else begin
            nRAS     <= 1'b1;
            nCAS     <= 1'b1;
            RASEL    <= 1'b0;
            nOE      <= 1'b1;
            nLWE     <= 1'b1;
            nUWE     <= 1'b1;
            RefAck   <= 1'b0;
            RAMReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (prechCnt != 2'd0) begin
                        prechCnt <= prechCnt - 2'd1;
                    end else if (refStart) begin
                        state  <= REF_CAS;
                        nCAS   <= 1'b0;
                        RefAck <= 1'b1;
                    end else if (ramReq) begin
                        state <= ACC_ROW;
                        nRAS  <= 1'b0;
                    end
                end
                ACC_ROW: begin
                    state    <= ACC_COL;
                    nRAS     <= 1'b0;
                    nCAS     <= 1'b0;
                    RASEL    <= 1'b1;
                    RAMReady <= 1'b1;
                    nOE      <= colOE;
                    nLWE     <= colLWE;
                    nUWE     <= colUWE;
                end
                ACC_COL: begin
                    if (BACT) begin
                        nRAS     <= 1'b0;
                        nCAS     <= 1'b0;
                        RASEL    <= 1'b1;
                        RAMReady <= 1'b1;
                        nOE      <= colOE;
                        nLWE     <= colLWE;
                        nUWE     <= colUWE;
                    end else begin
                        state    <= PRECH;
                        prechCnt <= TRP_CNT - 2'd1;
                    end
                end
                REF_CAS: begin
                    state <= REF_RAS;
                    nCAS  <= 1'b0;
                    nRAS  <= 1'b0;
                end
                REF_RAS: begin
                    state <= REF_HOLD;
                    nRAS  <= 1'b0;
                end
                REF_HOLD: begin
                    state    <= PRECH;
                    prechCnt <= TRP_CNT - 2'd1;
                end
                PRECH: begin
                    if (prechCnt == 2'd0) begin
                        state <= IDLE;
                    end else begin
                        prechCnt <= prechCnt - 2'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    prechCnt <= TRP_CNT;
                end
            endcase
        end
    end

    assign nROMOE = ~(BACT & ROMCS & nWE);

    rom_ws #(
        .ROMWS(ROMWS)
    ) romWaitStates (
        .CLK     (CLK),
        .nRES    (nRES),
        .BACT    (BACT),
        .ROMCS   (ROMCS),
        .ROMReady(ROMReady)
    );

endmodule

// File: doc/dram_sched.md
DRAM_SCHED -- requirements
Module: dram_sched

Interface
REQ-001 SHALL have parameter TRP, default 2, meaning precharge cycles after any RAS-low period (legal 1..3).
REQ-002 SHALL have parameter ROMWS, default 3, meaning ROM wait-state count before ROMReady (legal 0..7).
REQ-003 SHALL have port CLK  in  1  FSB clock; all state changes on rising edge.
REQ-004 SHALL have port nRES  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port BACT  in  1  FSB bus cycle active (qualified /AS).
REQ-006 SHALL have ports RAMCS, ROMCS  in  1 each  RAM / ROM space selects.
REQ-007 SHALL have ports nWE, nUDS, nLDS  in  1 each  FSB write strobe and byte strobes.
REQ-008 SHALL have ports RefReq, RefUrg  in  1 each  refresh request (deferrable) and urgent refresh (level, held until RefAck).
REQ-009 SHALL have port RefAck  out  1  one-cycle pulse when a refresh is started.
REQ-010 SHALL have ports nRAS, nCAS  out  1 each  DRAM strobes.
REQ-011 SHALL have port RASEL  out  1  address mux select: 0 = row, 1 = column.
REQ-012 SHALL have ports nOE, nLWE, nUWE  out  1 each  DRAM output enable, byte write enables.
REQ-013 SHALL have ports RAMReady, ROMReady, nROMOE  out  1 each  RAM cycle ready, ROM cycle ready, ROM output enable.

Function
REQ-014 SHALL implement states IDLE, ACC_ROW, ACC_COL, REF_CAS, REF_RAS, REF_HOLD, PRECH.
REQ-015 SHALL go IDLE->REF_CAS when RefUrg=1, or when RefReq=1 and not (BACT and RAMCS).
REQ-016 SHALL go IDLE->ACC_ROW when BACT and RAMCS and RefUrg=0; refresh wins ties with RefUrg.
REQ-017 SHALL in ACC_ROW drive nRAS=0, RASEL=0, then advance unconditionally to ACC_COL after 1 cycle.
REQ-018 SHALL in ACC_COL drive nRAS=0, nCAS=0, RASEL=1, RAMReady=1; reads nOE=0; writes nLWE=nLDS, nUWE=nUDS, nOE=1.
REQ-019 SHALL hold ACC_COL while BACT=1 and go to PRECH the cycle after BACT=0.
REQ-020 SHALL run CAS-before-RAS refresh: REF_CAS (nCAS=0, RefAck=1) -> REF_RAS (nCAS=0, nRAS=0) -> REF_HOLD (nRAS=0, nCAS=1) -> PRECH, one cycle each.
REQ-021 SHALL hold PRECH for exactly TRP cycles with nRAS=nCAS=1, then return to IDLE.
REQ-022 SHALL not preempt an access in progress; RefUrg during ACC_* is served from the next IDLE, ahead of any access.
REQ-023 SHALL hold RAMReady=0 for a RAM cycle arriving during refresh/PRECH; the access starts from IDLE if BACT still 1.
REQ-024 SHALL never drive nRAS or nCAS low in PRECH or IDLE, and never assert RefAck outside REF_CAS.
REQ-025 SHALL handle ROM independently of DRAM state: nROMOE = not(BACT and ROMCS and nWE), combinational.
REQ-026 SHALL count FSB cycles from BACT and ROMCS rising with a 3-bit saturating counter; ROMReady=1 once count >= ROMWS, cleared when BACT=0.
REQ-027 SHALL, with ROMWS=0, assert ROMReady in the first BACT cycle.
REQ-028 SHALL register all DRAM strobe outputs (nRAS, nCAS, RASEL, nOE, nLWE, nUWE, RefAck) so they are glitch-free.

Reset
REQ-029 SHALL on nRES=0 asynchronously enter IDLE: nRAS=nCAS=nOE=nLWE=nUWE=1, RASEL=0, RefAck=0, RAMReady=0, ROMReady=0, counters cleared.
REQ-030 SHALL abandon any access or refresh when reset hits mid-operation; after release, the first refresh or access still waits out one full TRP precharge.

Structure
REQ-031 SHALL place the state encoding and the TRP/ROMWS defaults in the shared package, for reuse by the RAM controller and testbench.
REQ-032 SHALL be a single module with the ROM wait-state counter as one sub-module, rom_ws.

Verification
REQ-033 SHALL cover: reset release, BACT=RAMCS=1 read -> nRAS low cycle 1, nCAS low plus RAMReady cycle 2, BACT drop -> 2 PRECH cycles -> IDLE.
REQ-034 SHALL cover: write with nUDS=0, nLDS=1 -> nUWE=0, nLWE=1, nOE=1 during ACC_COL.
REQ-035 SHALL cover: RefReq=1, idle bus -> RefAck pulse, nCAS falls one cycle before nRAS, 3-cycle refresh, then TRP precharge.
REQ-036 SHALL cover: RefUrg and RAM cycle arriving in the same IDLE cycle -> refresh first, RAMReady=0 until ACC_COL, 5+TRP cycles later.
REQ-037 SHALL cover: ROM read with ROMWS=3 during refresh -> nROMOE=0 immediately, ROMReady on 4th cycle, DRAM refresh unaffected.
REQ-038 SHALL cover: nRES asserted in ACC_COL -> nRAS, nCAS high in the same cycle, next access preceded by TRP precharge.
